turf_reset_sequencer: RTL
=========================

Name: turf_reset_sequencer

Overview:
- Register-driven controller that sequences the TURF clock-domain reset, the FPROG pulse and lock re-acquisition.
- Drives treset_o, then optionally FPROG, for programmable widths, then waits for tlock_i with a timeout.
- Optionally re-runs the sequence automatically when lock is lost.
- Sits on the same register write/readback bus as the other housekeeping blocks and owns the treset_o and FPROG pins outright.

Parameters:
RESET_CYCLES, 16, cycles treset_o is held high per sequence (≥1)
FPROG_CYCLES, 16, cycles FPROG is held high when selected (≥1)
LOCK_TIMEOUT_BITS, 12, lock wait limit = 2^LOCK_TIMEOUT_BITS cycles
CNT_WIDTH, 16, shared phase counter width; must hold the max of the three limits

Ports:
clk_i  in  1  system clock; everything is synchronous to it
rst_i  in  1  asynchronous active-high reset
wr_i  in  1  register write strobe, one cycle
dat_i  in  32  write data: [0] start, [1] include FPROG, [2] abort, [3] auto-relock enable, [4] write-enable for bit 3
dat_o  out  32  status readback (see Behaviour)
tlock_i  in  1  TURF lock, asynchronous to clk_i
treset_o  out  1  TURF reset, registered
FPROG  out  1  FPGA program pulse, registered
busy_o  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_i high): state=IDLE, counter=0, treset_o=0, FPROG=0, busy_o=0, auto_en=0, timeout_flag=0, lock_ok=0, retry_cnt=0, both lock sync flops=0.
- tlock_i passes through a 2-flop synchronizer to give lock_s. lock_s_d is lock_s delayed one cycle. A falling edge is lock_s_d=1 and lock_s=0.
- States: IDLE=0, RESET=1, FPROG=2, WAIT_LOCK=3.
- IDLE:
  - A wr_i with dat_i[0]=1 and dat_i[2]=0 goes to RESET on the next edge, with counter=0.
  - The start write latches fprog_sel=dat_i[1], and clears timeout_flag and lock_ok.
- RESET:
  - treset_o=1 for exactly RESET_CYCLES cycles. With a start write at edge t, treset_o is high from t+1 through t+RESET_CYCLES.
  - Exit goes to FPROG if fprog_sel, else WAIT_LOCK. The counter resets to 0 on every transition.
- FPROG:
  - FPROG=1 for exactly FPROG_CYCLES cycles. treset_o=0 in this state.
  - Exit goes to WAIT_LOCK.
- WAIT_LOCK:
  - treset_o=0 and FPROG=0.
  - When lock_s=1, go to IDLE and set lock_ok=1.
  - When the counter reaches 2^LOCK_TIMEOUT_BITS-1 with lock_s=0, go to IDLE and set timeout_flag=1 (sticky until the next start).
  - If lock_s=1 on the timeout cycle, lock wins.
- Abort:
  - wr_i with dat_i[2]=1 in any state goes to IDLE on the next edge. treset_o and FPROG are low from that edge. lock_ok and timeout_flag are unchanged.
  - Abort has priority over start in the same write.
- Start while busy: ignored; no restart and no flag change.
- Auto-relock:
  - auto_en is updated only by a write with dat_i[4]=1, taking auto_en=dat_i[3]. This is independent of start/abort in the same write.
  - Trigger condition: state=IDLE, auto_en=1, lock_ok=1, lock_s falling edge, and no write start/abort that cycle.
  - On trigger, start a sequence with fprog_sel=0 and increment retry_cnt, saturating at 15.
  - A timeout during an auto sequence clears lock_ok, so no further auto retries occur until software succeeds with a start.
  - A register start on the same cycle as an auto trigger wins; retry_cnt is not incremented.
  - retry_cnt clears only on rst_i.
- Counter: CNT_WIDTH-bit up-counter, cleared on every state entry, with no wrap inside any phase.
- dat_o layout:
  - [1:0] state, [2] busy_o, [3] lock_s, [4] lock_ok, [5] timeout_flag, [6] auto_en, [7] fprog_sel.
  - [11:8] retry_cnt, [15:12]=0, [31:16] counter[15:0] (zero-extended if CNT_WIDTH<16).
  - Fully registered, sampled from current state.
- rst_i asserted mid-sequence: outputs drop asynchronously to their reset values.

Test Plan:
- Reset, then tlock_i=1 held. Write 0x1 at edge t → treset_o high for t+1..t+16, FPROG never high, lock_ok=1 within 3 cycles after RESET exit, dat_o[4]=1, busy_o=0.
- Write 0x3 with tlock_i=0. After treset_o has fallen, raise tlock_i 100 cycles into WAIT_LOCK.
  - Required: treset_o high 16 cycles, then FPROG high 16 cycles, then IDLE about 3 cycles after the tlock_i rise, timeout_flag=0.
- Write 0x1 with tlock_i=0 throughout → WAIT_LOCK lasts 4096 cycles, then IDLE with timeout_flag=1 and lock_ok=0. A following write of 0x1 clears timeout_flag.
- Abort: write 0x3, then write 0x4 during FPROG at cycle 5 → FPROG low on the next edge, state=0. A write of 0x5 during RESET is treated as abort only.
- Auto-relock: write 0x18, then write 0x1 and achieve lock. Drop tlock_i → one automatic sequence (no FPROG), retry_cnt=1.
  - 20 further lock loss/recover cycles saturate retry_cnt at 15.
- Async reset: assert rst_i mid-RESET for a non-clock-aligned 3 ns → treset_o=0 immediately, dat_o=0 apart from counter=0.

Source files
------------

// File: rtl/turf_reset_sequencer.sv
// TURF reset sequencer: register-driven treset_o / FPROG pulse generation
// followed by a bounded wait for TURF lock, with optional automatic relock.
module turf_reset_sequencer #(
    parameter int unsigned RESET_CYCLES      = 16,
    parameter int unsigned FPROG_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_BITS = 12,
    parameter int unsigned CNT_WIDTH         = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        tlock_i,
    output logic        treset_o,
    output logic        FPROG,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RESET     = 2'd1,
        ST_FPROG     = 2'd2,
        ST_WAIT_LOCK = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] RESET_LAST   = CNT_WIDTH'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] FPROG_LAST   = CNT_WIDTH'(FPROG_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST =
        CNT_WIDTH'((64'd1 << LOCK_TIMEOUT_BITS) - 64'd1);

    state_t               state;
    logic [CNT_WIDTH-1:0] counter;
    logic                 fprog_sel;
    logic                 auto_en;
    logic                 timeout_flag;
    logic                 lock_ok;
    logic [3:0]           retry_cnt;
    logic                 lock_meta;
    logic                 lock_s;
    logic                 lock_s_d;

    logic wr_start_c;
    logic wr_abort_c;
    logic lock_fall_c;
    logic auto_trig_c;
    logic unused_dat_c;

    // Write decode and automatic relock trigger; abort outranks start.
    assign wr_start_c   = wr_i & dat_i[0] & ~dat_i[2];
    assign wr_abort_c   = wr_i & dat_i[2];
    assign lock_fall_c  = lock_s_d & ~lock_s;
    assign auto_trig_c  = (state == ST_IDLE) & auto_en & lock_ok & lock_fall_c
                        & ~(wr_i & (dat_i[0] | dat_i[2]));
    assign unused_dat_c = ^dat_i[31:5];

    // Lock synchronizer plus one-cycle delay for falling-edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
            lock_s_d  <= 1'b0;
        end else begin
            lock_meta <= tlock_i;
            lock_s    <= lock_meta;
            lock_s_d  <= lock_s;
        end
    end

    // Sequencer FSM with registered pin outputs, flags and status readback.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            counter      <= '0;
            treset_o     <= 1'b0;
            FPROG        <= 1'b0;
            busy_o       <= 1'b0;
            fprog_sel    <= 1'b0;
            auto_en      <= 1'b0;
            timeout_flag <= 1'b0;
            lock_ok      <= 1'b0;
            retry_cnt    <= 4'd0;
            dat_o        <= 32'd0;
        end else begin
            if (wr_i && dat_i[4]) begin
                auto_en <= dat_i[3];
            end

            if (wr_abort_c) begin
                state    <= ST_IDLE;
                counter  <= '0;
                treset_o <= 1'b0;
                FPROG    <= 1'b0;
                busy_o   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (wr_start_c) begin
                            state        <= ST_RESET;
                            counter      <= '0;
                            treset_o     <= 1'b1;
                            busy_o       <= 1'b1;
                            fprog_sel    <= dat_i[1];
                            timeout_flag <= 1'b0;
                            lock_ok      <= 1'b0;
                        end else if (auto_trig_c) begin
                            state     <= ST_RESET;
                            counter   <= '0;
                            treset_o  <= 1'b1;
                            busy_o    <= 1'b1;
                            fprog_sel <= 1'b0;
                            if (retry_cnt != 4'd15) begin
                                retry_cnt <= retry_cnt + 4'd1;
                            end
                        end
                    end
                    ST_RESET: begin
                        if (counter == RESET_LAST) begin
                            counter  <= '0;
                            treset_o <= 1'b0;
                            if (fprog_sel) begin
                                state <= ST_FPROG;
                                FPROG <= 1'b1;
                            end else begin
                                state <= ST_WAIT_LOCK;
                            end
                        end else begin
                            counter <= counter + CNT_WIDTH'(1);
                        end
                    end
                    ST_FPROG: begin
                        if (counter == FPROG_LAST) begin
                            counter <= '0;
                            FPROG   <= 1'b0;
                            state   <= ST_WAIT_LOCK;
                        end else begin
                            counter <= counter + CNT_WIDTH'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (lock_s) begin
                            state   <= ST_IDLE;
                            counter <= '0;
                            busy_o  <= 1'b0;
                            lock_ok <= 1'b1;
                        end else if (counter == TIMEOUT_LAST) begin
                            state        <= ST_IDLE;
                            counter      <= '0;
                            busy_o       <= 1'b0;
                            timeout_flag <= 1'b1;
                            lock_ok      <= 1'b0;
                        end else begin
                            counter <= counter + CNT_WIDTH'(1);
                        end
                    end
                    default: begin
                        state   <= ST_IDLE;
                        counter <= '0;
                    end
                endcase
            end

            dat_o <= {16'(counter), 4'd0, retry_cnt, fprog_sel, auto_en,
                      timeout_flag, lock_ok, lock_s, busy_o, state};
        end
    end

endmodule
